// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin and the converter returns bcd/busy/done.
// Optional feature macro: BCD_BLANK_EN adds the leading-zero blank mask.
interface bin_to_bcd_seq_if;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
`ifdef BCD_BLANK_EN
  logic [2:0]  blank;

  modport master (output start, bin, input bcd, busy, done, blank);
  modport slave  (input start, bin, output bcd, busy, done, blank);
`else
  modport master (output start, bin, input bcd, busy, done);
  modport slave  (input start, bin, output bcd, busy, done);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// One conversion takes 8 SHIFT cycles plus a DONE cycle that commits the
// result; bcd only ever changes on that commit, so partial values are never
// visible. Optional feature macro: BCD_BLANK_EN (leading-zero blank mask).
module bin_to_bcd_seq (
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  sreg_q;     // operand bits still to be shifted in
  logic [11:0] scratch_q;  // BCD digits under construction
  logic [2:0]  cnt_q;      // shifts completed, wraps 7 -> 0 on the last one
  logic [11:0] bcd_q;
  logic        done_q;
  logic [11:0] adj;        // scratch after the per-digit +3 correction
  logic        accept;

  // A digit of 5 or more would exceed 9 after doubling; +3 pre-corrects it.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept = (state_q == IDLE) && bus.start;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, matching real register behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> SHIFT on start, 8 shifts, one DONE cycle.
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)       state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7)   state_d = DONE;
      DONE:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Digit correction for all three digits in parallel.
  always_comb begin
    adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  end

  // Conversion datapath: load on accept, then correct-and-shift each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q    <= 8'h00;
      scratch_q <= 12'h000;
      cnt_q     <= 3'd0;
    end else if (accept) begin
      sreg_q    <= bus.bin;
      scratch_q <= 12'h000;
      cnt_q     <= 3'd0;
    end else if (state_q == SHIFT) begin
      scratch_q <= {adj[10:0], sreg_q[7]};
      sreg_q    <= {sreg_q[6:0], 1'b0};
      cnt_q     <= cnt_q + 3'd1;
    end
  end

  // Result commit: bcd and the done pulse update as DONE is left, so the new
  // value and done=1 appear together in the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q  <= 12'h000;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE) bcd_q <= scratch_q;
    end
  end

`ifdef BCD_BLANK_EN
  logic [2:0] blank_q;

  // Leading-zero mask, committed together with bcd; the ones digit always shows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= 3'b110;
    end else if (state_q == DONE) begin
      blank_q[2] <= (scratch_q[11:8] == 4'd0);
      blank_q[1] <= (scratch_q[11:8] == 4'd0) && (scratch_q[7:4] == 4'd0);
      blank_q[0] <= 1'b0;
    end
  end

  assign bus.blank = blank_q;
`endif

  assign bus.bcd  = bcd_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, hand-written
// corner sequences (ignored restart, held start, mid-conversion reset) and a
// full 0..255 sweep against a decimal reference model.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  bin_to_bcd_seq_if u_if ();

  bin_to_bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [11:0] ref_bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input logic [7:0] b);
    ref_blank = {b < 8'd100, b < 8'd10, 1'b0};
  endfunction

  // One full conversion: start accepted at edge N, busy for the 8 cycles after
  // edges N..N+7, done and the new bcd in the cycle after edge N+9, bcd stable
  // before that. bin is scrambled after acceptance to prove it is not re-read.
  task automatic do_conv(input logic [7:0] b, input logic [11:0] exp_bcd,
                         input logic [2:0] exp_blank, input string name);
    logic [11:0] prev;
    logic        timing_ok;
    timing_ok = 1'b1;
    @(negedge clk);
    prev = u_if.bcd;
    u_if.start = 1'b1;
    u_if.bin   = b;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        u_if.start = 1'b0;
        u_if.bin   = ~b;
      end
      if (u_if.busy !== (k <= 7)) timing_ok = 1'b0;
      if (u_if.done !== (k == 9)) timing_ok = 1'b0;
      if (u_if.done && u_if.busy) timing_ok = 1'b0;
      if (k < 9 && u_if.bcd !== prev) timing_ok = 1'b0;
    end
    check({name, "_timing"}, {31'd0, timing_ok}, 32'd1);
    check({name, "_bcd"}, {20'd0, u_if.bcd}, {20'd0, exp_bcd});
`ifdef BCD_BLANK_EN
    check({name, "_blank"}, {29'd0, u_if.blank}, {29'd0, exp_blank});
`else
    if (exp_blank === 3'bxxx) $display("unreachable");
`endif
  endtask

  initial begin
    int first_done;
    int second_done;
    int n_done;

    vecs[0] = '{8'd225, 12'h225, 3'b000};
    vecs[1] = '{8'd20,  12'h020, 3'b100};
    vecs[2] = '{8'd27,  12'h027, 3'b100};
    vecs[3] = '{8'd0,   12'h000, 3'b110};
    vecs[4] = '{8'd255, 12'h255, 3'b000};
    vecs[5] = '{8'd9,   12'h009, 3'b110};
    vecs[6] = '{8'd100, 12'h100, 3'b000};
    vecs[7] = '{8'd199, 12'h199, 3'b000};
    vecs[8] = '{8'd5,   12'h005, 3'b110};
    vecs[9] = '{8'd50,  12'h050, 3'b100};

    // Reset takes effect before any clock edge.
    reset      = 1'b0;
    u_if.start = 1'b0;
    u_if.bin   = 8'h00;
    #2;
    check("rst_bcd",  {20'd0, u_if.bcd}, 32'h0);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_done", {31'd0, u_if.done}, 32'd0);
`ifdef BCD_BLANK_EN
    check("rst_blank", {29'd0, u_if.blank}, 32'b110);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i].bin, vecs[i].bcd, vecs[i].blank, $sformatf("vec%0d", i));
    end

    // Restart attempts while busy and during DONE are ignored.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.bin   = 8'd42;
    @(posedge clk);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      u_if.start = (k == 3) || (k == 8);
      u_if.bin   = 8'd99;
      if (u_if.done) n_done++;
    end
    check("busy_restart_bcd",   {20'd0, u_if.bcd}, 32'h042);
    check("busy_restart_ndone", n_done, 32'd1);

    // Held start: one conversion every 10 cycles.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.bin   = 8'd77;
    @(posedge clk);
    first_done  = -1;
    second_done = -1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (u_if.done) begin
        if (first_done < 0)       first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    u_if.start = 1'b0;
    repeat (12) @(negedge clk);
    check("held_first_done",  first_done, 32'd9);
    check("held_second_done", second_done, 32'd19);
    check("held_bcd", {20'd0, u_if.bcd}, 32'h077);

    // Reset in the fourth SHIFT cycle aborts the conversion.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.bin   = 8'd200;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) u_if.start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, u_if.busy}, 32'd0);
    check("abort_bcd",  {20'd0, u_if.bcd}, 32'h0);
    check("abort_done", {31'd0, u_if.done}, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (u_if.done) n_done++;
    end
    check("abort_no_done", n_done, 32'd0);
    check("abort_bcd_held", {20'd0, u_if.bcd}, 32'h0);
    do_conv(8'd9, 12'h009, 3'b110, "after_abort");

    // Exhaustive sweep against the decimal reference.
    for (int i = 0; i < 256; i++) begin
      do_conv(8'(i), ref_bcd(8'(i)), ref_blank(8'(i)), $sformatf("sweep%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters: none; input width fixed at 8 bits, output fixed at 3 BCD digits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 bin  input  8  unsigned binary operand, typically the 8-bit product from s_multiplier; captured on the accepted start edge.
REQ-006 bcd  output  12  result: [11:8] hundreds, [7:4] tens, [3:0] ones; registered.
REQ-007 busy  output  1  high while a conversion is in progress (state SHIFT).
REQ-008 done  output  1  single-cycle pulse when bcd is updated.
REQ-009 blank  output  3  leading-zero blank mask, one bit per digit, [2] hundreds; present only with BCD_BLANK_EN (REQ-026).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 IDLE -> SHIFT on a rising edge with start=1: bin is copied to an 8-bit shift register, the 12-bit BCD scratch is cleared, and the 3-bit shift counter is set to 0.
REQ-012 In SHIFT, each cycle: any scratch digit >= 5 gets +3 (all three digits checked in parallel); then {scratch, shift reg} shifts left by 1; the counter increments.
REQ-013 SHIFT -> DONE after the 8th shift (counter wrap 7 -> 0); no extra idle cycle.
REQ-014 In DONE: bcd <= scratch, done=1 for that cycle only, next state IDLE.
REQ-015 Latency: start accepted at edge N -> done=1 and new bcd valid in the cycle after edge N+9.
REQ-016 bcd SHALL hold its value from DONE until the next DONE; it never shows partial results.
REQ-017 start while busy=1 or during DONE SHALL be ignored; no queuing; bin changes after acceptance have no effect.
REQ-018 start held high continuously SHALL start a new conversion on each IDLE visit (one every 10 cycles).
REQ-019 busy=1 exactly in SHIFT; done and busy never high together.
REQ-020 Every input 0..255 SHALL yield the exact decimal digits; no digit exceeds 9.

Reset
REQ-021 reset=0 SHALL immediately, without a clock edge, force IDLE, bcd=12'h000, busy=0, done=0, counter=0, scratch=0, shift reg=0.
REQ-022 Reset asserted mid-conversion SHALL abort it, with no done pulse and bcd=0.
REQ-023 After reset deasserts, the first start is accepted on the first rising edge with start=1.
REQ-024 With BCD_BLANK_EN defined, blank SHALL reset to 3'b110.

Configuration
REQ-025 Macro BCD_BLANK_EN.
REQ-026 With BCD_BLANK_EN defined, the blank port exists and is registered in DONE alongside bcd:
 - blank[2]=1 iff hundreds=0;
 - blank[1]=1 iff hundreds=0 and tens=0;
 - blank[0] always 0.
REQ-027 Without BCD_BLANK_EN, the blank port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 bin=8'd225 (15*15), start pulse -> done 9 cycles later, bcd=12'h225, blank=3'b000.
REQ-029 bin=8'd20, then bin=8'd27 in separate conversions -> bcd=12'h020 then 12'h027; blank=3'b100 both times.
REQ-030 bin=0 -> bcd=12'h000, blank=3'b110; bin=255 -> bcd=12'h255.
REQ-031 start re-pulsed with bin=8'd99 while busy -> ignored; result is that of the first operand; exactly one done pulse.
REQ-032 reset=0 at SHIFT cycle 4 -> bcd=0, busy=0 immediately; no done; a following start with bin=8'd9 -> bcd=12'h009.
REQ-033 Exhaustive sweep 0..255 against a reference model -> all match, busy/done timing per REQ-015 on every run.
